// File: rtl/arb_mux_pkg.sv
// rtl/arb_mux_pkg.sv - shared types and helpers for the arbitrated output mux
package arb_mux_pkg;

  // Arbitration mode as carried on the rr_en pin
  typedef enum logic {
    ARB_FIXED = 1'b0,
    ARB_RR    = 1'b1
  } arb_mode_t;

  // Width of a channel index; never narrower than one bit
  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/arb_mux_if.sv
// rtl/arb_mux_if.sv - producer-side and consumer-side handshake bundle
interface arb_mux_if
  import arb_mux_pkg::*;
#(
  parameter int N = 8,
  parameter int W = 4
) ();

  localparam int IW = idx_w(N);

  logic [N-1:0]  in_valid;
  logic [W-1:0]  in_data [N];
  logic [N-1:0]  in_ready;
  logic          out_valid;
  logic [W-1:0]  out_data;
  logic [IW-1:0] out_sel;
  logic          out_ready;

  // Drives the channels and consumes the output beat
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sel
  );

  // The mux itself
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sel
  );

endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin / fixed-priority grant
module rr_arbiter
  import arb_mux_pkg::*;
#(
  parameter int  N  = 8,
  localparam int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          rr_en,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] g
);

  arb_mode_t     w_mode;
  logic [IW-1:0] w_start;
  logic [IW-1:0] w_bit;
  logic          w_found;
  int            w_idx;

  assign w_mode  = arb_mode_t'(rr_en);
  // Fixed priority is just a round-robin scan that always starts at channel 0
  assign w_start = (w_mode == ARB_RR) ? ptr : '0;

  // Scan start, start+1, ... with wrap at N; the first requester wins
  always_comb begin
    grant   = '0;
    g       = '0;
    w_found = 1'b0;
    w_idx   = 0;
    w_bit   = '0;
    for (int k = 0; k < N; k++) begin
      w_idx = int'(w_start) + k;
      if (w_idx >= N) w_idx = w_idx - N;
      w_bit = IW'(w_idx);
      if (!w_found && req[w_bit]) begin
        w_found      = 1'b1;
        grant[w_bit] = 1'b1;
        g            = w_bit;
      end
    end
  end

endmodule

// File: rtl/arb_mux.sv
// rtl/arb_mux.sv - arbitrated N-to-1 mux with a registered valid/ready output
module arb_mux
  import arb_mux_pkg::*;
#(
  parameter int N = 8,
  parameter int W = 4
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      rr_en,
  arb_mux_if.slave  bus
);

  localparam int IW = idx_w(N);

  logic [IW-1:0] r_ptr;
  logic          r_out_valid;
  logic [W-1:0]  r_out_data;
  logic [IW-1:0] r_out_sel;

  logic          w_load;
  logic [N-1:0]  w_grant;
  logic [IW-1:0] w_g;
  logic [N-1:0]  w_ready;
  logic          w_xfer;
  logic [IW-1:0] w_ptr_next;

  rr_arbiter #(.N(N)) u_arb (
    .req   (bus.in_valid),
    .ptr   (r_ptr),
    .rr_en (rr_en),
    .grant (w_grant),
    .g     (w_g)
  );

  // The register can take a new beat when empty or when its beat leaves now
  assign w_load     = !r_out_valid || bus.out_ready;
  // Grant is already qualified by in_valid; reset cycles never hand out a slot
  assign w_ready    = (w_load && !reset) ? w_grant : '0;
  assign w_xfer     = |w_ready;
  // Explicit wrap so non-power-of-two N never lands on an unused index
  assign w_ptr_next = (int'(w_g) == N - 1) ? '0 : w_g + IW'(1);

  assign bus.in_ready  = w_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_sel   = r_out_sel;

  // Output register and round-robin pointer; data/sel keep their value once drained
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sel   <= '0;
    end else if (w_xfer) begin
      r_out_valid <= 1'b1;
      r_out_data  <= bus.in_data[w_g];
      r_out_sel   <= w_g;
      r_ptr       <= w_ptr_next;
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_arb_mux.sv
// tb/tb_arb_mux.sv - scoreboard bench for arb_mux (N=8, W=4)
module tb_arb_mux;

  logic clk;
  logic reset;
  logic rr_en;

  arb_mux_if #(.N(8), .W(4)) bus ();

  arb_mux #(.N(8), .W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .rr_en (rr_en),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] data_tab [8];
  logic [6:0] sb [$];
  logic [6:0] sb_head;
  int         n_checks;
  int         n_fail;
  int         m_ptr;
  logic       m_valid;
  logic       m_load;
  logic       m_found;
  int         m_g;
  int         m_idx;
  logic [7:0] m_ready;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: own grant scan, pushes expected beats, pops on output transfer
  always @(negedge clk) begin
    if (reset) begin
      chk("rst_in_ready", bus.in_ready, 0);
      sb.delete();
      m_ptr   = 0;
      m_valid = 1'b0;
    end else begin
      chk("sb_valid", bus.out_valid, m_valid);
      m_load  = !m_valid || bus.out_ready;
      m_found = 1'b0;
      m_g     = 0;
      for (int k = 0; k < 8; k++) begin
        m_idx = rr_en ? (m_ptr + k) % 8 : k;
        if (!m_found && bus.in_valid[m_idx]) begin
          m_found = 1'b1;
          m_g     = m_idx;
        end
      end
      m_ready = (m_load && m_found) ? (8'h01 << m_g) : 8'h00;
      chk("sb_in_ready", bus.in_ready, m_ready);
      if (bus.out_valid && bus.out_ready) begin
        chk("sb_nonempty", (sb.size() > 0), 1);
        if (sb.size() > 0) begin
          sb_head = sb.pop_front();
          chk("sb_sel", bus.out_sel, sb_head[6:4]);
          chk("sb_data", bus.out_data, sb_head[3:0]);
        end
      end
      if (m_ready != 8'h00) begin
        sb.push_back({3'(m_g), data_tab[m_g]});
        m_ptr   = (m_g + 1) % 8;
        m_valid = 1'b1;
      end else if (bus.out_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  initial begin
    logic [2:0] rr_sel_exp [8];
    n_checks = 0;
    n_fail   = 0;
    m_ptr    = 0;
    m_valid  = 1'b0;
    data_tab[0] = 4'hF; data_tab[1] = 4'hE; data_tab[2] = 4'hD; data_tab[3] = 4'hB;
    data_tab[4] = 4'h7; data_tab[5] = 4'hC; data_tab[6] = 4'hA; data_tab[7] = 4'hC;
    for (int i = 0; i < 8; i++) begin
      bus.in_data[i] = data_tab[i];
      rr_sel_exp[i]  = 3'(i);
    end
    reset         = 1'b1;
    rr_en         = 1'b1;
    bus.in_valid  = 8'hFF;
    bus.out_ready = 1'b1;

    // Reset held across two edges with every channel requesting
    @(negedge clk);
    chk("rst_ready", bus.in_ready, 8'h00);
    chk("rst_valid", bus.out_valid, 1'b0);
    chk("rst_data", bus.out_data, 4'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", bus.in_ready, 8'h01);
    chk("post_rst_valid", bus.out_valid, 1'b0);
    chk("post_rst_data", bus.out_data, 4'h0);

    // Round-robin with all valid; stall arrives right after channel 3 is loaded
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k == 12) bus.out_ready = 1'b0;
      @(negedge clk);
      if (k <= 10) begin
        chk("rr_sel", bus.out_sel, rr_sel_exp[(k - 1) % 8]);
        chk("rr_data", bus.out_data, data_tab[(k - 1) % 8]);
      end
    end

    // Backpressure: three stalled cycles holding channel 3
    for (int j = 0; j < 3; j++) begin
      if (j > 0) begin
        tick();
        @(negedge clk);
      end
      chk("bp_sel", bus.out_sel, 3'd3);
      chk("bp_data", bus.out_data, 4'hB);
      chk("bp_valid", bus.out_valid, 1'b1);
      chk("bp_ready", bus.in_ready, 8'h00);
      chk("bp_ptr", dut.r_ptr, 3'd4);
    end
    tick();
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", bus.in_ready, 8'h10);
    tick();
    @(negedge clk);
    chk("bp_next_sel", bus.out_sel, 3'd4);
    chk("bp_next_data", bus.out_data, 4'h7);
    chk("bp_next_valid", bus.out_valid, 1'b1);

    // Fixed priority: channel 2 wins every cycle, 6 starves
    tick();
    rr_en        = 1'b0;
    bus.in_valid = 8'h44;
    for (int c = 0; c < 4; c++) begin
      if (c > 0) tick();
      @(negedge clk);
      chk("fp_ready", bus.in_ready, 8'h04);
      if (c > 0) begin
        chk("fp_sel", bus.out_sel, 3'd2);
        chk("fp_data", bus.out_data, 4'hD);
      end
    end

    // Move ptr to 7 via channel 6, then a lone request on 1 must wrap
    tick();
    rr_en        = 1'b1;
    bus.in_valid = 8'h40;
    @(negedge clk);
    chk("wrap_pre_ready", bus.in_ready, 8'h40);
    tick();
    bus.in_valid = 8'h02;
    @(negedge clk);
    chk("wrap_ptr7", dut.r_ptr, 3'd7);
    chk("wrap_ready", bus.in_ready, 8'h02);
    tick();
    bus.in_valid = 8'h00;
    @(negedge clk);
    chk("wrap_ptr2", dut.r_ptr, 3'd2);
    chk("wrap_sel", bus.out_sel, 3'd1);
    chk("wrap_data", bus.out_data, 4'hE);
    chk("wrap_valid", bus.out_valid, 1'b1);
    tick();
    @(negedge clk);
    chk("drain_valid", bus.out_valid, 1'b0);
    chk("drain_data", bus.out_data, 4'hE);

    // Reset while a beat is stalled: the beat must vanish
    tick();
    bus.out_ready = 1'b0;
    bus.in_valid  = 8'h20;
    @(negedge clk);
    chk("ms_load_ready", bus.in_ready, 8'h20);
    tick();
    bus.in_valid = 8'h00;
    @(negedge clk);
    chk("ms_held_valid", bus.out_valid, 1'b1);
    chk("ms_held_sel", bus.out_sel, 3'd5);
    tick();
    reset = 1'b1;
    @(negedge clk);
    chk("ms_rst_ready", bus.in_ready, 8'h00);
    tick();
    reset         = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("ms_valid", bus.out_valid, 1'b0);
    chk("ms_ptr", dut.r_ptr, 3'd0);
    tick();
    @(negedge clk);
    chk("ms_after_valid", bus.out_valid, 1'b0);

    // Random traffic checked by the scoreboard
    for (int r = 0; r < 300; r++) begin
      tick();
      bus.in_valid  = 8'($urandom);
      rr_en         = 1'($urandom);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
    end
    tick();
    bus.in_valid  = 8'h00;
    bus.out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      tick();
    end
    chk("final_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/arb_mux.md
# arb_mux

Parametrised, registered N-to-1 multiplexer with its own arbiter, the next generation of the team's 8-way 4-bit combinational mux. The select is no longer an external input. The block chooses among requesting channels by round-robin or fixed priority. It moves one beat per cycle through a valid/ready output register, and it sits between several producer channels and a single shared consumer.

## Interface
Parameters:
- N, default 8: number of input channels, 2..16.
- W, default 4: data width per channel, 1..64.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- rr_en  input  1  1 = round-robin arbitration, 0 = fixed priority (lowest index wins).
- in_valid  input  N  per-channel request; bit i means in_data[i] is offered.
- in_data  input  N x W  unpacked array of channel data.
- in_ready  output  N  one-hot or zero; bit i high means channel i transfers this cycle.
- out_valid  output  1  output register holds a beat.
- out_data  output  W  registered data of the held beat.
- out_sel  output  $clog2(N)  index of the channel that supplied the held beat.
- out_ready  input  1  consumer accepts the beat this cycle.

## Operation
- load = !out_valid || out_ready. The output register may load this cycle.
- Grant g:
  - rr_en=1: the first set in_valid bit scanning ptr, ptr+1, …, N-1, 0, …, ptr-1.
  - rr_en=0: the lowest set in_valid bit.
- in_ready[g] = load && in_valid[g]. All other in_ready bits are 0. With no request, in_ready = 0.
- Input transfer: in_valid[i] && in_ready[i]. On transfer, out_data <= in_data[g], out_sel <= g, out_valid <= 1.
- Output transfer: out_valid && out_ready. If no input transfers in the same cycle, out_valid <= 0. out_data and out_sel then keep their last values.
- Round-robin pointer ptr ($clog2(N) bits): on every input transfer, ptr <= (g+1) mod N. The wrap from N-1 goes to 0, including when N is not a power of two. ptr is unchanged when there is no transfer and is retained across rr_en changes.
- Stall (out_valid && !out_ready): out_data and out_sel are held stable, in_ready = 0, and ptr does not move.
- Channel rules:
  - A channel must hold in_valid and in_data until it is granted.
  - The block never drops or duplicates a beat.

## Timing
- Reset values: out_valid=0, out_data=0, out_sel=0, ptr=0, in_ready=0 during the reset cycle.
- Reset mid-operation discards any held beat. No in_ready is asserted in a reset cycle.
- Latency: 1 cycle from input transfer to out_valid.
- Throughput: 1 beat per cycle when out_ready is held high.
- Combinational paths:
  - out_ready → in_ready. This is the only path from output to input side.
  - in_valid → in_ready.
  - There is no path from in_data to any output.
- Simultaneous output and input transfer: the register is replaced in the same edge, and out_valid stays 1.
- rr_en changes take effect in the same cycle's grant.
- Fairness: with rr_en=1 and all N channels continuously valid, each channel is granted exactly once every N transfers.

## Structure
- Package arb_mux_pkg holds:
  - the clog2-based index-width helper function;
  - enum arb_mode_t {ARB_FIXED=0, ARB_RR=1}, used to decode rr_en.
- Sub-module rr_arbiter (parameter N): inputs req[N], ptr, rr_en; outputs one-hot grant[N] and index g. It is purely combinational.
- arb_mux owns ptr, the output register and the handshake logic.
- Expected size is about 150–250 lines total.

## Test plan
All scenarios use N=8, W=4, in_data[i] = {4'hF,4'hE,4'hD,4'hB,4'h7,4'hC,4'hA,4'hC} for i=0..7.

- Reset: assert reset for 2 cycles with all in_valid=1. Required: out_valid=0, out_data=0, in_ready=0. On the first cycle after release, ptr=0, so in_ready=8'b0000_0001.
- Fixed priority: rr_en=0, in_valid=8'b0100_0100, out_ready=1. Required: channel 2 is granted every cycle and out_data=4'hD, out_sel=2 continuously. Channel 6 is starved.
- Round-robin: rr_en=1, all valid, out_ready=1 for 10 cycles. Required: out_sel sequence 0,1,2,3,4,5,6,7,0,1 and out_data F,E,D,B,7,C,A,C,F,E.
- Backpressure: after a beat from channel 3 is loaded, drop out_ready for 3 cycles. Required: out_data=4'hB and out_sel=3 stay stable, in_ready=0, ptr stays at 4. Raise out_ready: channel 4 beat (4'h7) appears on the next cycle with no gap.
- Sparse/wrap: rr_en=1, ptr=7, in_valid=8'b0000_0010. Required: grant 1, then ptr=2. Then drop all in_valid with out_ready=1: out_valid falls to 0 one cycle later, and out_data holds 4'hE.
- Reset mid-stall: hold a beat with out_ready=0, then pulse reset for 1 cycle. Required: out_valid=0 and ptr=0 after the edge, and the held beat is never delivered.
